// File: rtl/simon_controller_if.sv
// Datapath handshake between the Simon controller (master) and its counter/memory datapath (slave).
interface simon_controller_if;
   logic index_lt_count;
   logic pattern_eq_mem;
   logic pattern_valid;
   logic count_cnt;
   logic count_clr;
   logic index_cnt;
   logic index_clr;
   logic write_en;
   logic load_level;
   logic disp_mem;

   modport master (
      input  index_lt_count,
      input  pattern_eq_mem,
      input  pattern_valid,
      output count_cnt,
      output count_clr,
      output index_cnt,
      output index_clr,
      output write_en,
      output load_level,
      output disp_mem
   );

   modport slave (
      output index_lt_count,
      output pattern_eq_mem,
      output pattern_valid,
      input  count_cnt,
      input  count_clr,
      input  index_cnt,
      input  index_clr,
      input  write_en,
      input  load_level,
      input  disp_mem
   );
endinterface

// File: rtl/simon_controller.sv
// Simon game control FSM: record, play back and check switch patterns against datapath memory.
// Define SIMON_PLAYBACK_HOLD_EN to hold each displayed entry for HOLD_CYCLES clock cycles.
module simon_controller #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       btn,
   simon_controller_if.master         dp,
   output logic [3:0]                 mode_leds
);

   localparam logic [2:0] StInit     = 3'd0;
   localparam logic [2:0] StInput    = 3'd1;
   localparam logic [2:0] StPlayback = 3'd2;
   localparam logic [2:0] StRepeat   = 3'd3;
   localparam logic [2:0] StDone     = 3'd4;

   localparam logic [5:0] LastRound = 6'd63;

   logic [2:0] state_q, state_d;
   logic       btn_q;
   logic [5:0] round_q, round_d;
   logic       press;
   logic       step;

   logic       count_cnt, count_clr, index_cnt, index_clr;
   logic       write_en, load_level, disp_mem;
   logic [3:0] leds;

   assign press = btn & ~btn_q;

`ifdef SIMON_PLAYBACK_HOLD_EN
   localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);

   logic [15:0] hold_q, hold_d;

   assign step = (hold_q == HoldLast);

   // Restart the hold on entry to a display state and after every step.
   always_comb begin
      hold_d = '0;
      if ((state_d == StPlayback || state_d == StDone) && state_d == state_q && !step) begin
         hold_d = hold_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   logic unused_hold_cycles;

   assign unused_hold_cycles = (HOLD_CYCLES != 0);
   assign step = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      count_cnt  = 1'b0;
      count_clr  = 1'b0;
      index_cnt  = 1'b0;
      index_clr  = 1'b0;
      write_en   = 1'b0;
      load_level = 1'b0;
      disp_mem   = 1'b0;
      leds       = 4'b0000;

      case (state_q)
         StInit: begin
            count_clr  = 1'b1;
            index_clr  = 1'b1;
            load_level = 1'b1;
            state_d    = StInput;
         end
         StInput: begin
            leds = 4'b0001;
            if (press && dp.pattern_valid) begin
               index_clr = 1'b1;
               if (round_q != LastRound) begin
                  write_en  = 1'b1;
                  count_cnt = 1'b1;
                  state_d   = StPlayback;
               end else begin
                  state_d   = StDone;
               end
            end
         end
         StPlayback: begin
            leds     = 4'b0010;
            disp_mem = dp.index_lt_count;
            if (dp.index_lt_count) begin
               index_cnt = step;
            end else begin
               index_clr = 1'b1;
               state_d   = StRepeat;
            end
         end
         StRepeat: begin
            leds = 4'b0100;
            // Round completion takes priority over a coincident press.
            if (!dp.index_lt_count) begin
               index_clr = 1'b1;
               state_d   = StInput;
            end else if (press) begin
               if (dp.pattern_eq_mem) begin
                  index_cnt = 1'b1;
               end else begin
                  index_clr = 1'b1;
                  state_d   = StDone;
               end
            end
         end
         StDone: begin
            leds     = 4'b1000;
            disp_mem = dp.index_lt_count;
            if (step) begin
               index_cnt = dp.index_lt_count;
               index_clr = ~dp.index_lt_count;
            end
         end
         default: begin
            state_d = StInit;
         end
      endcase

      // Outputs are quiet for the whole reset pulse, independent of the state decode.
      if (rst) begin
         count_cnt  = 1'b0;
         count_clr  = 1'b0;
         index_cnt  = 1'b0;
         index_clr  = 1'b0;
         write_en   = 1'b0;
         load_level = 1'b0;
         disp_mem   = 1'b0;
         leds       = 4'b0000;
      end
   end

   always_comb begin
      round_d = round_q;
      if (count_clr) begin
         round_d = '0;
      end else if (count_cnt) begin
         round_d = round_q + 6'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StInit;
         btn_q   <= 1'b0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn;
         round_q <= round_d;
      end
   end

   assign dp.count_cnt  = count_cnt;
   assign dp.count_clr  = count_clr;
   assign dp.index_cnt  = index_cnt;
   assign dp.index_clr  = index_clr;
   assign dp.write_en   = write_en;
   assign dp.load_level = load_level;
   assign dp.disp_mem   = disp_mem;
   assign mode_leds     = leds;

endmodule

// File: tb/tb_simon_controller.sv
// Directed bench for simon_controller with a small behavioural datapath (count, index, memory).
module tb_simon_controller;

`ifdef SIMON_PLAYBACK_HOLD_EN
   localparam int Hold = 4;
`else
   localparam int Hold = 1;
`endif

   localparam logic [6:0] Cnt  = 7'b1000000;
   localparam logic [6:0] Cclr = 7'b0100000;
   localparam logic [6:0] Icnt = 7'b0010000;
   localparam logic [6:0] Iclr = 7'b0001000;
   localparam logic [6:0] Wr   = 7'b0000100;
   localparam logic [6:0] Ld   = 7'b0000010;
   localparam logic [6:0] Disp = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic [3:0] mode_leds;
   logic [6:0] ctl;

   logic [6:0] cnt = '0;
   logic [6:0] idx = '0;
   logic [3:0] mem [64];
   logic [3:0] sw = '0;
   logic       valid = 1'b0;
   logic       lt_kill = 1'b0;
   int         wr_pulses = 0;

   int checks = 0;
   int errors = 0;

   simon_controller_if dp ();

   simon_controller #(.HOLD_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .dp        (dp),
      .mode_leds (mode_leds)
   );

   always #5 clk = ~clk;

   assign ctl = {dp.count_cnt, dp.count_clr, dp.index_cnt, dp.index_clr,
                 dp.write_en, dp.load_level, dp.disp_mem};

   assign dp.index_lt_count = (idx < cnt) && !lt_kill;
   assign dp.pattern_eq_mem = (sw == mem[idx[5:0]]);
   assign dp.pattern_valid  = valid;

   always @(posedge clk) begin
      if (dp.count_clr) cnt <= '0;
      else if (dp.count_cnt) cnt <= cnt + 7'd1;
      if (dp.index_clr) idx <= '0;
      else if (dp.index_cnt) idx <= idx + 7'd1;
      if (dp.write_en) begin
         mem[cnt[5:0]] <= sw;
         wr_pulses     <= wr_pulses + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // n entries displayed for Hold cycles each, index stepping on the last cycle
   task automatic show_entries(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         for (int h = 0; h < Hold; h++) begin
            if (h == 0) chk({tag, "_idx"}, int'(idx), k);
            chk(tag, int'(ctl), int'(Disp | ((h == Hold - 1) ? Icnt : 7'b0)));
            tick();
         end
      end
   endtask

   // Plays one full round correctly from INPUT back to INPUT.
   task automatic auto_round(input int r);
      int n;
      btn = 1'b0; tick();
      sw = 4'(r); valid = 1'b1; btn = 1'b1; tick();
      btn = 1'b0;
      for (int t = 0; t < 1000 && mode_leds != 4'b0100; t++) tick();
      chk("auto_repeat", int'(mode_leds), 4'b0100);
      n = int'(cnt);
      for (int k = 0; k < n; k++) begin
         sw = mem[k]; btn = 1'b1; tick();
         btn = 1'b0; tick();
      end
      for (int t = 0; t < 1000 && mode_leds != 4'b0001; t++) tick();
      chk("auto_input", int'(mode_leds), 4'b0001);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and start-up
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mode", int'(mode_leds), 0);
      chk("rst_ctl", int'(ctl), 0);
      rst = 1'b0; #1;
      chk("init_ctl", int'(ctl), int'(Cclr | Iclr | Ld));
      chk("init_mode", int'(mode_leds), 0);
      tick();
      chk("input_mode", int'(mode_leds), 4'b0001);
      chk("input_ctl", int'(ctl), 0);

      // Round 1: held button, then press coincident with round completion
      sw = 4'h3; valid = 1'b1; btn = 1'b1; #1;
      chk("r1_write", int'(ctl), int'(Cnt | Iclr | Wr));
      tick();
      chk("r1_play_mode", int'(mode_leds), 4'b0010);
      show_entries(1, "r1_play");
      chk("r1_play_end", int'(ctl), int'(Iclr));
      tick();
      for (int i = 0; i < 7; i++) begin
         chk("r1_held", int'(ctl), 0);
         tick();
      end
      chk("r1_writes", wr_pulses, 1);
      chk("r1_rep_mode", int'(mode_leds), 4'b0100);
      btn = 1'b0; tick();
      lt_kill = 1'b1; sw = 4'hf; btn = 1'b1; #1;
      chk("r1_coincide", int'(ctl), int'(Iclr));
      tick();
      lt_kill = 1'b0;
      chk("r1_to_input", int'(mode_leds), 4'b0001);

      // Round 2: invalid press ignored, then two matching presses
      valid = 1'b0; btn = 1'b0; tick();
      btn = 1'b1; #1;
      chk("r2_invalid", int'(ctl), 0);
      tick();
      chk("r2_stay", int'(mode_leds), 4'b0001);
      valid = 1'b1; btn = 1'b0; tick();
      sw = 4'h5; btn = 1'b1; #1;
      chk("r2_write", int'(ctl), int'(Cnt | Iclr | Wr));
      tick();
      show_entries(2, "r2_play");
      chk("r2_play_end", int'(ctl), int'(Iclr));
      tick();
      chk("r2_rep_mode", int'(mode_leds), 4'b0100);
      btn = 1'b0; tick();
      sw = 4'h3; btn = 1'b1; #1;
      chk("r2_match0", int'(ctl), int'(Icnt));
      tick();
      btn = 1'b0; tick();
      sw = 4'h5; btn = 1'b1; #1;
      chk("r2_match1", int'(ctl), int'(Icnt));
      tick();
      chk("r2_rep_end", int'(ctl), int'(Iclr));
      tick();
      chk("r2_to_input", int'(mode_leds), 4'b0001);

      // Round 3: playback of three entries, match then mismatch into DONE
      btn = 1'b0; tick();
      sw = 4'h9; btn = 1'b1; #1;
      chk("r3_write", int'(ctl), int'(Cnt | Iclr | Wr));
      tick();
      show_entries(3, "r3_play");
      chk("r3_play_end", int'(ctl), int'(Iclr));
      tick();
      chk("r3_rep_mode", int'(mode_leds), 4'b0100);
      btn = 1'b0; tick();
      sw = 4'h3; btn = 1'b1; #1;
      chk("r3_match", int'(ctl), int'(Icnt));
      tick();
      btn = 1'b0; tick();
      sw = 4'hf; btn = 1'b1; #1;
      chk("r3_mismatch", int'(ctl), int'(Iclr));
      tick();
      chk("r3_done", int'(mode_leds), 4'b1000);
      for (int lap = 0; lap < 2; lap++) begin
         show_entries(3, "done_loop");
         for (int h = 0; h < Hold; h++) begin
            chk("done_wrap", int'(ctl), int'((h == Hold - 1) ? Iclr : 7'b0));
            chk("done_mode", int'(mode_leds), 4'b1000);
            tick();
         end
      end

      // Reset from DONE, one write, then reset asserted mid-PLAYBACK
      btn = 1'b0; rst = 1'b1; tick();
      rst = 1'b0; #1;
      tick();
      sw = 4'h7; btn = 1'b1; #1;
      chk("rs_write", int'(ctl), int'(Cnt | Iclr | Wr));
      tick();
      chk("rs_play_mode", int'(mode_leds), 4'b0010);
      chk("rs_play_ctl", int'(ctl), int'(Disp | ((Hold == 1) ? Icnt : 7'b0)));
      #2; rst = 1'b1; #1;
      chk("rs_async_mode", int'(mode_leds), 0);
      chk("rs_async_ctl", int'(ctl), 0);
      btn = 1'b0; tick();
      chk("rs_held_mode", int'(mode_leds), 0);
      rst = 1'b0; #1;
      chk("rs_init_ctl", int'(ctl), int'(Cclr | Iclr | Ld));
      tick();
      chk("rs_input_mode", int'(mode_leds), 4'b0001);
      chk("rs_count_zero", int'(cnt), 0);

      // 63 full rounds from round 0, then the final press must not write
      for (int r = 0; r < 63; r++) auto_round(r);
      chk("full_count", int'(cnt), 63);
      btn = 1'b0; tick();
      sw = 4'h2; valid = 1'b1; btn = 1'b1; #1;
      chk("last_press", int'(ctl), int'(Iclr));
      tick();
      chk("last_done", int'(mode_leds), 4'b1000);
      chk("last_count", int'(cnt), 63);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
